// File: rtl/heat_pkg.sv
// Shared encodings for the heat-solver pin protocol: host ops, pin modes,
// solver configuration register indices and host FSM states.
package heat_pkg;

  localparam int CELLS = 64;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_CONFIG = 2'd1,
    OP_RUN    = 2'd2,
    OP_DUMP   = 2'd3
  } op_t;

  localparam logic [1:0] MODE_RUN = 2'b00;
  localparam logic [1:0] MODE_WR  = 2'b01;
  localparam logic [1:0] MODE_RD  = 2'b10;
  localparam logic [1:0] MODE_CFG = 2'b11;

  localparam logic [2:0] CFG_ALPHA   = 3'd0;
  localparam logic [2:0] CFG_BTEMP   = 3'd1;
  localparam logic [2:0] CFG_BTYPE   = 3'd2;
  localparam logic [2:0] CFG_HSADDR  = 3'd3;
  localparam logic [2:0] CFG_HSTEMP  = 3'd4;
  localparam logic [2:0] CFG_HSEN    = 3'd5;
  localparam logic [2:0] CFG_CLRCNT  = 3'd6;
  localparam logic [2:0] CFG_PATTERN = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CFG,
    S_RUN,
    S_ADDR,
    S_WAIT,
    S_SAMPLE
  } state_t;

endpackage

// File: rtl/heat_grid_host.sv
// Host-side initiator: turns LOAD/CONFIG/RUN/DUMP commands into registered
// per-cycle solver pin sequences, with valid/ready nibble streams for grid data.
module heat_grid_host
  import heat_pkg::*;
#(
  parameter int CELLS  = heat_pkg::CELLS,
  parameter int ADDR_W = 6,
  parameter int ITER_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ITER_W-1:0] cmd_arg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        pin_mode,
  output logic [ADDR_W-1:0] pin_addr,
  output logic [7:0]        pin_wr,
  input  logic [3:0]        pin_rd
);

  localparam int CNT_W = ITER_W + ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [7:0]        wcnt, wcnt_next;
  logic [1:0]        mode_next;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        wr_next;
  logic [3:0]        data_next;
  logic              done_next;
  logic              last_idx;

  // Streams use plain valid/ready: a beat transfers on a rising edge where both
  // are high; the producer holds data stable while valid is high and ready low.
  assign last_idx  = (idx == ADDR_W'(CELLS - 1));
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_SAMPLE);
  assign out_last  = out_valid && last_idx;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    wcnt_next  = wcnt;
    mode_next  = MODE_RD;
    addr_next  = '0;
    wr_next    = '0;
    data_next  = out_data;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_next = '0;
          // CONFIG and RUN drive their first pin cycle straight off the accept edge.
          case (op_t'(cmd_op))
            OP_LOAD: state_next = S_LOAD;
            OP_CONFIG: begin
              state_next = S_CFG;
              mode_next  = MODE_CFG;
              addr_next  = ADDR_W'(cmd_arg[10:8]);
              wr_next    = {2'b00, cmd_arg[5:0]};
            end
            OP_RUN: begin
              state_next = S_RUN;
              if (cmd_arg == '0) begin
                cnt_next = '0;
              end else begin
                cnt_next  = CNT_W'(cmd_arg) * CNT_W'(CELLS) - CNT_W'(1);
                mode_next = MODE_RUN;
              end
            end
            OP_DUMP: state_next = S_ADDR;
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mode_next = MODE_WR;
          addr_next = idx;
          wr_next   = {4'b0000, in_data};
          idx_next  = idx + 1'b1;
          if (last_idx) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      S_CFG: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      S_RUN: begin
        if (cnt == '0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next  = cnt - CNT_W'(1);
          mode_next = MODE_RUN;
        end
      end
      S_ADDR: begin
        addr_next = idx;
        if (RD_LAT == 0) begin
          data_next  = pin_rd;
          state_next = S_SAMPLE;
        end else begin
          wcnt_next  = 8'(RD_LAT - 1);
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        addr_next = idx;
        if (wcnt == '0) begin
          data_next  = pin_rd;
          state_next = S_SAMPLE;
        end else begin
          wcnt_next = wcnt - 8'd1;
        end
      end
      S_SAMPLE: begin
        addr_next = idx;
        if (out_ready) begin
          if (last_idx) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
            addr_next  = '0;
          end else begin
            idx_next   = idx + 1'b1;
            addr_next  = idx + 1'b1;
            state_next = S_ADDR;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      pin_mode <= MODE_RD;
      pin_addr <= '0;
      pin_wr   <= '0;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      cnt      <= cnt_next;
      wcnt     <= wcnt_next;
      pin_mode <= mode_next;
      pin_addr <= addr_next;
      pin_wr   <= wr_next;
      out_data <= data_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_heat_grid_host.sv
// Bench for heat_grid_host: a pin-level solver model (8x8 grid, registered read
// path) plus scoreboard queues for expected writes, config writes and dump beats.
module tb_heat_grid_host;
  import heat_pkg::*;

  localparam int RD_LAT = 1;
  localparam int GRID_W = 8;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        in_valid, in_ready;
  logic [3:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [3:0]  out_data;
  logic        busy, done;
  logic [1:0]  pin_mode;
  logic [5:0]  pin_addr;
  logic [7:0]  pin_wr;
  logic [3:0]  pin_rd;

  heat_grid_host #(.CELLS(CELLS), .ADDR_W(6), .ITER_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done),
    .pin_mode(pin_mode), .pin_addr(pin_addr), .pin_wr(pin_wr), .pin_rd(pin_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] exp_q[$];
  logic [13:0] cfg_q[$];
  logic [4:0]  dump_q[$];

  logic [3:0] mem[CELLS] = '{default: 4'h0};
  logic [3:0] snap[CELLS];
  logic [5:0] cfg[8] = '{default: 6'h0};
  logic [3:0] rd_stage;
  logic [3:0] pat[CELLS];
  int run_phase, run_total, burst_len, burst_cnt, last_burst_len;
  int wr_seen, cfg_seen, done_cnt;
  logic prev_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [3:0] stencil_cell(input int i, input logic [3:0] g[CELLS],
                                              input int alpha, input logic [3:0] bt);
    int r, c, n, s, e, w, d, v;
    r = i / GRID_W;
    c = i % GRID_W;
    n = (r > 0) ? int'(g[i-GRID_W]) : int'(bt);
    s = (r < GRID_W - 1) ? int'(g[i+GRID_W]) : int'(bt);
    w = (c > 0) ? int'(g[i-1]) : int'(bt);
    e = (c < GRID_W - 1) ? int'(g[i+1]) : int'(bt);
    d = n + s + e + w - 4 * int'(g[i]);
    v = int'(g[i]) + (d >>> alpha);
    if (v < 0) v = 0;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  // Solver model: acts on each cycle's pin values, one iteration per CELLS run cycles.
  always @(negedge clk) begin
    if (rst) begin
      run_phase = 0;
      prev_run  = 1'b0;
      burst_len = 0;
      rd_stage  = 4'h0;
      pin_rd    = 4'h0;
    end else begin
      if (done) done_cnt++;
      case (pin_mode)
        MODE_WR: begin
          wr_seen++;
          check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("wr_pins", 32'({pin_addr, pin_wr}), 32'(exp_q.pop_front()));
          mem[pin_addr] = pin_wr[3:0];
        end
        MODE_CFG: begin
          cfg_seen++;
          check("cfg_expected", 32'(cfg_q.size() != 0), 32'd1);
          if (cfg_q.size() != 0) check("cfg_pins", 32'({pin_addr, pin_wr}), 32'(cfg_q.pop_front()));
          cfg[pin_addr[2:0]] = pin_wr[5:0];
        end
        MODE_RUN: begin
          run_total++;
          run_phase++;
          if (run_phase == CELLS) begin
            run_phase = 0;
            snap = mem;
            for (int i = 0; i < CELLS; i++) mem[i] = stencil_cell(i, snap, int'(cfg[0]), cfg[1][3:0]);
          end
        end
        default: ;
      endcase
      if (pin_mode == MODE_RUN) begin
        burst_len++;
      end else if (prev_run) begin
        burst_cnt++;
        last_burst_len = burst_len;
        burst_len = 0;
      end
      prev_run = (pin_mode == MODE_RUN);
      pin_rd   = rd_stage;
      rd_stage = mem[pin_addr];
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < budget);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic drain_dump(input string tag, input int stall_beat);
    int t;
    logic [4:0] held;
    for (int b = 0; b < CELLS; b++) begin
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        held = {out_last, out_data};
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'({out_last, out_data}), 32'(held));
          check("stall_addr", 32'(pin_addr), 32'(stall_beat));
        end
        out_ready = 1'b1;
      end
      check({tag, "_beat"}, 32'({out_last, out_data}), 32'(dump_q.pop_front()));
      @(posedge clk);
    end
  endtask

  int lat, d0, w0, c0, b0, r0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    run_total = 0; burst_cnt = 0; last_burst_len = 0;
    wr_seen = 0; cfg_seen = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_mode", 32'(pin_mode), 32'(MODE_RD));
    check("rst_addr", 32'(pin_addr), 32'd0);
    check("rst_wr", 32'(pin_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // LOAD temp[i] = i%16, one beat every other cycle
    d0 = done_cnt; w0 = wr_seen;
    send_cmd(OP_LOAD, 16'd0);
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      if (i == 0) check("load_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 4'(i % 16);
      exp_q.push_back({6'(i), 8'(i % 16)});
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    wait_done("load", 20, lat);
    @(negedge clk);
    check("load_writes", 32'(wr_seen - w0), 32'd64);
    check("load_queue_empty", 32'(exp_q.size()), 32'd0);
    check("load_single_done", 32'(done_cnt - d0), 32'd1);
    check("load_in_ready_low", 32'(in_ready), 32'd0);

    // DUMP the i%16 grid with a 3-cycle stall at beat 10
    for (int i = 0; i < CELLS; i++) dump_q.push_back({i == CELLS - 1, 4'(i % 16)});
    d0 = done_cnt;
    send_cmd(OP_DUMP, 16'd0);
    out_ready = 1'b1;
    drain_dump("dump", 10);
    wait_done("dump", 10, lat);
    check("dump_done_latency", 32'(lat), 32'd1);
    @(negedge clk);
    check("dump_queue_empty", 32'(dump_q.size()), 32'd0);
    check("dump_single_done", 32'(done_cnt - d0), 32'd1);
    check("dump_valid_low", 32'(out_valid), 32'd0);

    // CONFIG reg 3 = 27
    c0 = cfg_seen;
    cfg_q.push_back({6'd3, 8'h1B});
    send_cmd(OP_CONFIG, 16'h031B);
    wait_done("config", 10, lat);
    check("config_latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("config_cycles", 32'(cfg_seen - c0), 32'd1);
    check("config_queue_empty", 32'(cfg_q.size()), 32'd0);

    // RUN 0 then RUN 2
    r0 = run_total;
    send_cmd(OP_RUN, 16'd0);
    wait_done("run0", 10, lat);
    check("run0_latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("run0_no_run_cycles", 32'(run_total - r0), 32'd0);
    b0 = burst_cnt;
    send_cmd(OP_RUN, 16'd2);
    wait_done("run2", 300, lat);
    check("run2_latency", 32'(lat), 32'd129);
    @(negedge clk);
    check("run2_bursts", 32'(burst_cnt - b0), 32'd1);
    check("run2_burst_len", 32'(last_burst_len), 32'd128);

    // Reset in the middle of RUN 5
    send_cmd(OP_RUN, 16'd5);
    repeat (20) @(negedge clk);
    check("run_mid_mode", 32'(pin_mode), 32'(MODE_RUN));
    rst = 1'b1;
    #1;
    check("rst_mid_mode", 32'(pin_mode), 32'(MODE_RD));
    check("rst_mid_addr", 32'(pin_addr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = run_total; d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_run_after", 32'(run_total - r0), 32'd0);
    check("rst_no_done_after", 32'(done_cnt - d0), 32'd0);

    // Integration: hot 2x2 block, ALPHA=2, one iteration, dump vs golden stencil
    for (int i = 0; i < CELLS; i++)
      pat[i] = (i == 27 || i == 28 || i == 35 || i == 36) ? 4'd15 : 4'd0;
    send_cmd(OP_LOAD, 16'd0);
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pat[i];
      exp_q.push_back({6'(i), 4'h0, pat[i]});
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    wait_done("int_load", 20, lat);
    cfg_q.push_back({6'(CFG_ALPHA), 8'd2});
    send_cmd(OP_CONFIG, {5'd0, CFG_ALPHA, 8'd2});
    wait_done("int_config", 10, lat);
    send_cmd(OP_RUN, 16'd1);
    wait_done("int_run", 100, lat);
    for (int i = 0; i < CELLS; i++)
      dump_q.push_back({i == CELLS - 1, stencil_cell(i, pat, 2, 4'd0)});
    send_cmd(OP_DUMP, 16'd0);
    out_ready = 1'b1;
    drain_dump("int_dump", -1);
    wait_done("int_dump", 10, lat);
    @(negedge clk);
    check("int_queue_empty", 32'(dump_q.size() + exp_q.size() + cfg_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/heat_grid_host.md
Name: heat_grid_host

Overview:
- Host-side initiator for the heat-solver pin protocol: generates `mode[1:0]`, `addr[5:0]` and write data, and samples read data.
- Turns high-level commands into exact per-cycle pin sequences: LOAD grid, CONFIG register, RUN N iterations, DUMP grid.
- Sits in the FPGA/test harness (or a companion tile) that drives the solver's `ui_in`/`uio` pins; grid data flows over valid/ready streams.

Parameters:
- CELLS, 64, number of grid cells addressed (0..CELLS-1).
- ADDR_W, 6, pin address width.
- ITER_W, 16, iteration-count width for RUN.
- RD_LAT, 1, extra wait cycles between driving a read address and sampling `pin_rd` (min 0).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOAD, 1=CONFIG, 2=RUN, 3=DUMP.
- cmd_arg  in  ITER_W  RUN: iteration count; CONFIG: [10:8]=reg index, [5:0]=value.
- in_valid/in_ready  in/out  1/1  LOAD nibble stream.
- in_data  in  4  LOAD temperature.
- out_valid/out_ready  out/in  1/1  DUMP nibble stream.
- out_data  out  4  DUMP temperature.
- out_last  out  1  high with the cell CELLS-1 beat.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- pin_mode  out  2  solver mode pins.
- pin_addr  out  ADDR_W  solver address pins.
- pin_wr  out  8  solver `uio_in`; upper bits are 0 except CONFIG value.
- pin_rd  in  4  solver `uio_out[3:0]`.

Behaviour:
- All pin outputs are registered.
- Reset state: IDLE, pin_mode=2'b10, pin_addr=0, pin_wr=0, out_valid=0, in_ready=0, done=0, busy=0.
- Parked pin state: in IDLE and every stall cycle, pin_mode=2'b10 (read, harmless). pin_mode=2'b00 is never driven outside RUN.
- IDLE: on cmd_valid&cmd_ready, latch op/arg, clear cell counter `idx`, go to the op state.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid: pin_mode=01, pin_addr=idx, pin_wr={4'b0,in_data}, idx++.
  - No beat that cycle: parked pins.
  - Beat with idx==CELLS-1 completes: IDLE plus done.
- CONFIG: exactly one cycle of pin_mode=11, pin_addr={3'b0,arg[10:8]}, pin_wr={2'b0,arg[5:0]}; then parked pins, done, IDLE.
- RUN:
  - arg==0: done the next cycle; no mode-00 cycle.
  - Otherwise pin_mode=00 for exactly arg*CELLS consecutive cycles.
  - Cycle counter width is ITER_W+ADDR_W, loaded as arg*CELLS-1, decremented to 0.
  - Then parked pins, done.
- DUMP is a loop over three states:
  - ADDR: pin_mode=10, pin_addr=idx.
  - WAIT: RD_LAT cycles.
  - SAMPLE: capture pin_rd into out_data; out_valid=1.
  - Hold out_valid, out_data and pin_addr until out_ready.
  - On handshake: idx++ and back to ADDR; or, if idx==CELLS-1 (out_last=1), IDLE plus done.
  - Sample timing: pin_addr is driven from edge k; pin_rd is sampled at edge k+1+RD_LAT.
- Exclusivity: cmd_ready=0 while busy. A command presented while busy is not accepted and is held by the requester. in_ready=0 outside LOAD; out_valid=0 outside DUMP.
- Reset mid-operation: everything returns to reset values immediately (async). A partially loaded grid stays as written in the solver. No further pin activity occurs.
- done asserts in the cycle IDLE is re-entered; busy deasserts in that same cycle.

Decomposition:
- Shared package `heat_pkg`:
  - op encodings.
  - mode encodings MODE_RUN=00, MODE_WR=01, MODE_RD=10, MODE_CFG=11.
  - config indices: ALPHA=0, BTEMP=1, BTYPE=2, HSADDR=3, HSTEMP=4, HSEN=5, CLRCNT=6, PATTERN=7.
  - CELLS.
- Single module. No sub-module is needed. The FSM, idx counter and run counter fit in roughly 200 lines.

Test Plan:
- Reset → pin_mode=10, pin_addr=0, busy=0, cmd_ready=1; then assert rst mid-RUN → pin_mode returns to 10 in the same cycle.
- LOAD with in_valid toggled every other cycle, data=idx[3:0] → 64 mode-01 writes at addr 0..63 in order, parked cycles in between, single done after the 64th beat.
- CONFIG arg={reg 3, value 27} → exactly one cycle pin_mode=11, pin_addr=3, pin_wr=0x1B, then done.
- RUN arg=2 → exactly 128 consecutive pin_mode=00 cycles; RUN arg=0 → zero mode-00 cycles, done one cycle after accept.
- DUMP against a solver model preloaded with temp[i]=i%16, RD_LAT=1, out_ready stalled 3 cycles at beat 10 → out_data sequence 0..15 repeated, no duplicates or drops, out_last only on beat 63.
- Integration: LOAD a pattern with 15 at cells 27/28/35/36, CONFIG ALPHA=2, RUN 1, DUMP → output matches the golden stencil model bit-exact.
